draw_compositor: RTL and testbench

//  Pipelined pixel colour stage between the VGA timing generator and the RGB/sync pins.

---
 rtl/drawcon_pkg.sv | 13 +
 rtl/draw_compositor_if.sv | 30 +++
 rtl/pix_delay.sv | 24 ++
 rtl/draw_compositor.sv | 140 ++++++++++++++
 tb/tb_draw_compositor.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/drawcon_pkg.sv
// rtl/drawcon_pkg.sv - shared colour types and RGB332 expansion for draw_compositor
package drawcon_pkg;

    typedef logic [11:0] rgb12_t;

    localparam rgb12_t RGB_BLACK = 12'h000;

    // Bit replication keeps full-scale codes at full scale (8'hFF -> 12'hFFF).
    function automatic rgb12_t rgb332_to_rgb12(input logic [7:0] d);
        return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
    endfunction

endpackage

// File: rtl/draw_compositor_if.sv
// rtl/draw_compositor_if.sv - pixel timing/ROM inputs and colour/sync outputs of draw_compositor
interface draw_compositor_if #(
    parameter int XW      = 11,
    parameter int YW      = 10,
    parameter int NUM_SPR = 2
);
    logic                   pix_en;
    logic [XW-1:0]          draw_x;
    logic [YW-1:0]          draw_y;
    logic                   hsync_in;
    logic                   vsync_in;
    logic [7:0]             bg_data;
    logic [8*NUM_SPR-1:0]   spr_data;
    logic [NUM_SPR-1:0]     spr_hit;
    logic [3:0]             draw_r;
    logic [3:0]             draw_g;
    logic [3:0]             draw_b;
    logic                   hsync_out;
    logic                   vsync_out;

    modport master (
        output pix_en, draw_x, draw_y, hsync_in, vsync_in, bg_data, spr_data, spr_hit,
        input  draw_r, draw_g, draw_b, hsync_out, vsync_out
    );

    modport slave (
        input  pix_en, draw_x, draw_y, hsync_in, vsync_in, bg_data, spr_data, spr_hit,
        output draw_r, draw_g, draw_b, hsync_out, vsync_out
    );
endinterface

// File: rtl/pix_delay.sv
// rtl/pix_delay.sv - fixed-depth shift register with a parameterised reset value
module pix_delay #(
    parameter int           W       = 1,
    parameter int           DEPTH   = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];
endmodule

// File: rtl/draw_compositor.sv
// rtl/draw_compositor.sv - background/sprite/border pixel compositor with sync alignment
// Optional border flashing is built when DRAWCON_BORDER_FLASH_EN is defined.
module draw_compositor
    import drawcon_pkg::*;
#(
    parameter int          XW           = 11,
    parameter int          YW           = 10,
    parameter int          H_ACT        = 1280,
    parameter int          V_ACT        = 800,
    parameter int          BORDER       = 10,
    parameter logic [11:0] BORDER_RGB   = 12'hFFF,
    parameter int          NUM_SPR      = 2,
    parameter logic [7:0]  TRANSP_KEY   = 8'hE3,
    parameter int          ROM_LAT      = 1,
    parameter logic        SYNC_IDLE    = 1'b1,
    parameter int          FLASH_FRAMES = 30
) (
    input  logic            clk,
    input  logic            rst_n,
    draw_compositor_if.slave pix
);
    localparam int AW = XW + YW + 1;
    localparam logic [XW-1:0] X_END   = XW'(H_ACT);
    localparam logic [YW-1:0] Y_END   = YW'(V_ACT);
    localparam logic [XW-1:0] X_BR_LO = XW'(BORDER);
    localparam logic [XW-1:0] X_BR_HI = XW'(H_ACT - BORDER);
    localparam logic [YW-1:0] Y_BR_LO = YW'(BORDER);
    localparam logic [YW-1:0] Y_BR_HI = YW'(V_ACT - BORDER);

    if (NUM_SPR < 1 || NUM_SPR > 8 || ROM_LAT < 1 || ROM_LAT > 4 || FLASH_FRAMES < 1) begin : g_bad_cfg
        $error("draw_compositor: parameter out of range");
    end

    logic [AW-1:0] pos_a;
    logic [XW-1:0] x_a;
    logic [YW-1:0] y_a;
    logic          pen_a;
    logic          hs_a;
    logic          vs_a;

    // Position and syncs are delayed to line up with the ROM bytes.
    pix_delay #(.W(AW), .DEPTH(ROM_LAT), .RST_VAL({AW{1'b0}})) u_pos_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   ({pix.draw_x, pix.draw_y, pix.pix_en}),
        .q_o   (pos_a)
    );

    pix_delay #(.W(2), .DEPTH(ROM_LAT), .RST_VAL({SYNC_IDLE, SYNC_IDLE})) u_sync_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   ({pix.hsync_in, pix.vsync_in}),
        .q_o   ({hs_a, vs_a})
    );

    assign {x_a, y_a, pen_a} = pos_a;

    rgb12_t layer_rgb;
    rgb12_t border_rgb;
    rgb12_t rgb_d;
    rgb12_t rgb_q;
    logic   blank;
    logic   in_border;
    logic   hs_q;
    logic   vs_q;

    // Walk from the lowest-priority layer up so layer 0 is applied last and wins.
    always_comb begin
        layer_rgb = rgb332_to_rgb12(pix.bg_data);
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (pix.spr_hit[i] && (pix.spr_data[8*i +: 8] != TRANSP_KEY))
                layer_rgb = rgb332_to_rgb12(pix.spr_data[8*i +: 8]);
        end
    end

    assign blank     = !pen_a || (x_a >= X_END) || (y_a >= Y_END);
    assign in_border = (x_a < X_BR_LO) || (x_a >= X_BR_HI) || (y_a < Y_BR_LO) || (y_a >= Y_BR_HI);

`ifdef DRAWCON_BORDER_FLASH_EN
    localparam int FCW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    logic           vs_prev_q;
    logic [FCW-1:0] frame_q;
    logic [FCW-1:0] frame_d;
    logic           phase_q;
    logic           phase_d;
    logic           frame_start;

    assign frame_start = (vs_prev_q == SYNC_IDLE) && (pix.vsync_in != SYNC_IDLE);

    always_comb begin
        frame_d = frame_q;
        phase_d = phase_q;
        if (frame_start) begin
            if (frame_q == FCW'(FLASH_FRAMES - 1)) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev_q <= SYNC_IDLE;
            frame_q   <= '0;
            phase_q   <= 1'b0;
        end else begin
            vs_prev_q <= pix.vsync_in;
            frame_q   <= frame_d;
            phase_q   <= phase_d;
        end
    end

    assign border_rgb = phase_q ? ~BORDER_RGB : BORDER_RGB;
`else
    assign border_rgb = BORDER_RGB;
`endif

    assign rgb_d = blank ? RGB_BLACK : (in_border ? border_rgb : layer_rgb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= RGB_BLACK;
            hs_q  <= SYNC_IDLE;
            vs_q  <= SYNC_IDLE;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= hs_a;
            vs_q  <= vs_a;
        end
    end

    assign pix.draw_r    = rgb_q[11:8];
    assign pix.draw_g    = rgb_q[7:4];
    assign pix.draw_b    = rgb_q[3:0];
    assign pix.hsync_out = hs_q;
    assign pix.vsync_out = vs_q;
endmodule

// File: tb/tb_draw_compositor.sv
// tb/tb_draw_compositor.sv - table and random checks of draw_compositor against a reference model
module tb_draw_compositor;
    localparam int XW      = 11;
    localparam int YW      = 10;
    localparam int NSPR    = 2;
    localparam int ROM_LAT = 1;
    localparam int H_ACT   = 1280;
    localparam int V_ACT   = 800;
    localparam int BORDER  = 10;
    localparam int NRAND   = 300;

    typedef struct {
        logic [XW-1:0]     x;
        logic [YW-1:0]     y;
        logic              pen;
        logic              hs;
        logic              vs;
        logic [7:0]        bg;
        logic [8*NSPR-1:0] spr;
        logic [NSPR-1:0]   hit;
        logic [11:0]       rgb;
    } vec_t;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    vec_t stim[$];

    draw_compositor_if #(.XW(XW), .YW(YW), .NUM_SPR(NSPR)) bus ();

    draw_compositor #(
        .XW(XW), .YW(YW), .H_ACT(H_ACT), .V_ACT(V_ACT), .BORDER(BORDER),
        .BORDER_RGB(12'hFFF), .NUM_SPR(NSPR), .TRANSP_KEY(8'hE3),
        .ROM_LAT(ROM_LAT), .SYNC_IDLE(1'b1), .FLASH_FRAMES(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pix   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] expand(input logic [7:0] dd);
        int d, r3, g3, b2;
        d  = int'(dd);
        r3 = d / 32;
        g3 = (d / 4) % 8;
        b2 = d % 4;
        return 12'((r3 * 2 + r3 / 4) * 256 + (g3 * 2 + g3 / 4) * 16 + b2 * 5);
    endfunction

    function automatic logic [11:0] ref_rgb(input vec_t v);
        int x, y;
        logic [7:0] d;
        x = int'(v.x);
        y = int'(v.y);
        if (!v.pen || x >= H_ACT || y >= V_ACT) return 12'h000;
        if (x < BORDER || x >= H_ACT - BORDER || y < BORDER || y >= V_ACT - BORDER) return 12'hFFF;
        for (int i = 0; i < NSPR; i++) begin
            d = v.spr[8*i +: 8];
            if (v.hit[i] && d != 8'hE3) return expand(d);
        end
        return expand(v.bg);
    endfunction

    function automatic vec_t mk(input int x, input int y, input bit pen, input bit hs, input bit vs,
                                input logic [7:0] bg, input logic [15:0] spr, input logic [1:0] hit,
                                input logic [11:0] rgb);
        vec_t v;
        v.x = XW'(x); v.y = YW'(y); v.pen = pen; v.hs = hs; v.vs = vs;
        v.bg = bg; v.spr = spr; v.hit = hit; v.rgb = rgb;
        return v;
    endfunction

    task automatic drive_xy(input vec_t v);
        bus.draw_x = v.x; bus.draw_y = v.y; bus.pix_en = v.pen;
        bus.hsync_in = v.hs; bus.vsync_in = v.vs;
    endtask

    task automatic drive_rom(input vec_t v);
        bus.bg_data = v.bg; bus.spr_data = v.spr; bus.spr_hit = v.hit;
    endtask

    task automatic check(input string name, input logic [11:0] rgb, input logic hs, input logic vs);
        logic [11:0] act;
        act = {bus.draw_r, bus.draw_g, bus.draw_b};
        vectors++;
        if (act !== rgb || bus.hsync_out !== hs || bus.vsync_out !== vs) begin
            miscompares++;
            $display("FAIL %s: got rgb=%h hs=%b vs=%b, expected rgb=%h hs=%b vs=%b",
                     name, act, bus.hsync_out, bus.vsync_out, rgb, hs, vs);
        end
    endtask

    task automatic hold_check(input string name, input vec_t v);
        drive_xy(v);
        drive_rom(v);
        repeat (ROM_LAT + 2) @(negedge clk);
        check(name, v.rgb, v.hs, v.vs);
    endtask

    task automatic vsync_pulse(input vec_t v);
        vec_t p;
        p = v;
        p.vs = 1'b0;
        drive_xy(p);
        repeat (2) @(negedge clk);
        drive_xy(v);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        vec_t v, idle, px;
        int   n, nv;
        bit   vs_rand;
        vectors = 0;
        miscompares = 0;
        idle = mk(0, 0, 0, 1, 1, 8'h00, 16'h0000, 2'b00, 12'h000);

        stim.push_back(mk(100, 100, 1, 0, 1, 8'hFF, 16'h0000, 2'b00, 12'hFFF));
        stim.push_back(mk(5,   100, 1, 1, 0, 8'h00, 16'h0000, 2'b00, 12'hFFF));
        stim.push_back(mk(1270,100, 1, 0, 0, 8'h00, 16'h0000, 2'b00, 12'hFFF));
        stim.push_back(mk(100, 795, 1, 1, 1, 8'h00, 16'h0000, 2'b00, 12'hFFF));
        stim.push_back(mk(1280,100, 1, 0, 1, 8'hFF, 16'h0000, 2'b00, 12'h000));
        stim.push_back(mk(200, 200, 0, 1, 1, 8'hFF, 16'h0000, 2'b00, 12'h000));
        stim.push_back(mk(200, 200, 1, 1, 1, 8'h03, 16'h1CE0, 2'b11, 12'hF00));
        stim.push_back(mk(200, 200, 1, 0, 1, 8'h03, 16'h1CE3, 2'b11, 12'h0F0));
        stim.push_back(mk(200, 200, 1, 1, 0, 8'h03, 16'h1CE0, 2'b00, 12'h00F));
        stim.push_back(mk(300, 300, 1, 1, 1, 8'h00, 16'h0000, 2'b00, 12'h000));
        stim.push_back(mk(300, 300, 1, 0, 0, 8'hFF, 16'h0000, 2'b00, 12'hFFF));
        stim.push_back(mk(300, 300, 1, 1, 1, 8'h92, 16'h0000, 2'b00, 12'h99A));
        stim.push_back(mk(9,   400, 1, 1, 1, 8'h92, 16'h0000, 2'b00, 12'hFFF));
        stim.push_back(mk(10,  10,  1, 1, 1, 8'h92, 16'h0000, 2'b00, 12'h99A));
        stim.push_back(mk(1269,789, 1, 1, 1, 8'h92, 16'h0000, 2'b00, 12'h99A));
        stim.push_back(mk(500, 790, 1, 1, 1, 8'h92, 16'h0000, 2'b00, 12'hFFF));
        stim.push_back(mk(500, 800, 1, 1, 1, 8'h92, 16'h0000, 2'b00, 12'h000));
        stim.push_back(mk(1279,500, 1, 1, 1, 8'h92, 16'h0000, 2'b00, 12'hFFF));
        stim.push_back(mk(500, 500, 1, 1, 1, 8'h92, 16'hE3E0, 2'b10, 12'h99A));

`ifdef DRAWCON_BORDER_FLASH_EN
        vs_rand = 1'b0;
        foreach (stim[i]) stim[i].vs = 1'b1;
`else
        vs_rand = 1'b1;
`endif
        for (int i = 0; i < NRAND; i++) begin
            int xs[8];
            int ys[6];
            xs = '{0, 9, 10, 1269, 1270, 1279, 1280, 2047};
            ys = '{0, 9, 10, 789, 790, 1023};
            v.x   = ($urandom_range(0, 3) == 0) ? XW'(xs[$urandom_range(0, 7)]) : XW'($urandom_range(0, 1400));
            v.y   = ($urandom_range(0, 3) == 0) ? YW'(ys[$urandom_range(0, 5)]) : YW'($urandom_range(0, 900));
            v.pen = ($urandom_range(0, 9) != 0);
            v.hs  = 1'($urandom);
            v.vs  = vs_rand ? 1'($urandom) : 1'b1;
            v.bg  = 8'($urandom);
            for (int k = 0; k < NSPR; k++)
                v.spr[8*k +: 8] = ($urandom_range(0, 3) == 0) ? 8'hE3 : 8'($urandom);
            v.hit = NSPR'($urandom);
            v.rgb = ref_rgb(v);
            stim.push_back(v);
        end

        rst_n = 1'b0;
        drive_xy(idle);
        drive_rom(idle);
        for (int i = 0; i < 3; i++) begin
            v.x = XW'($urandom); v.y = YW'($urandom); v.pen = 1'($urandom);
            v.hs = 1'b0; v.vs = 1'b0; v.bg = 8'($urandom); v.spr = 16'($urandom); v.hit = 2'b11;
            drive_xy(v);
            drive_rom(v);
            @(negedge clk);
            check("reset_hold", 12'h000, 1'b1, 1'b1);
        end

        @(negedge clk);
        rst_n = 1'b1;
        nv = stim.size();
        for (n = 0; n <= nv + ROM_LAT; n++) begin
            if (n <= ROM_LAT) check("post_reset_idle", 12'h000, 1'b1, 1'b1);
            else check($sformatf("vec%0d", n - ROM_LAT - 1), stim[n-ROM_LAT-1].rgb,
                       stim[n-ROM_LAT-1].hs, stim[n-ROM_LAT-1].vs);
            drive_xy((n < nv) ? stim[n] : idle);
            if (n >= ROM_LAT && n - ROM_LAT < nv) drive_rom(stim[n-ROM_LAT]);
            else drive_rom(idle);
            @(negedge clk);
        end

        px = mk(100, 100, 1, 0, 1, 8'hFF, 16'h0000, 2'b00, 12'hFFF);
        hold_check("steady_pixel", px);
        rst_n = 1'b0;
        @(negedge clk);
        check("midframe_reset", 12'h000, 1'b1, 1'b1);
        rst_n = 1'b1;
        for (int k = 1; k <= ROM_LAT + 1; k++) begin
            @(negedge clk);
            if (k <= ROM_LAT) check("refill_idle", 12'h000, 1'b1, 1'b1);
            else check("refill_first", 12'hFFF, 1'b0, 1'b1);
        end

`ifdef DRAWCON_BORDER_FLASH_EN
        px = mk(5, 100, 1, 1, 1, 8'h00, 16'h0000, 2'b00, 12'hFFF);
        hold_check("flash_f0", px);
        for (int f = 1; f <= 6; f++) begin
            vsync_pulse(px);
            px.rgb = (f == 2 || f == 3 || f == 6) ? 12'h000 : 12'hFFF;
            hold_check($sformatf("flash_f%0d", f), px);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        px.rgb = 12'hFFF;
        hold_check("flash_after_reset", px);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
